vga_pixel_fifo: RTL and testbench

- Single-clock pixel buffer sitting directly upstream of the VGA controller's RGB inputs.
- Accepts 24-bit RGB pixels from the frame source over a valid/ready handshake.
- Pops one pixel per cycle while the controller asserts its read request, presenting R/G/B one cycle later.
- Flushes at frame start, flags underflow, and raises a low-watermark refill request for the source.

---
 rtl/vga_pixel_fifo.sv | 101 ++++++++++
 tb/tb_vga_pixel_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: single-clock 24-bit pixel buffer feeding the VGA controller.
// Source side: iWR_DATA/iWR_VALID/oWR_READY handshake.
// Sink side: iREAD_Request pops one pixel; oRed/oGreen/oBlue present it one cycle
// later, or black when there is no request or the buffer is empty.
// iFRAME_START flushes the buffer. oFILL reports the occupancy, oLOW_WATER asks
// the source for a refill, and oUNDERFLOW is a sticky empty-read flag.
// iRST is a synchronous, active-high reset.
module vga_pixel_fifo #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned LOW_WM = 128
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFRAME_START,
    input  logic [23:0]       iWR_DATA,
    input  logic              iWR_VALID,
    output logic              oWR_READY,
    input  logic              iREAD_Request,
    output logic [7:0]        oRed,
    output logic [7:0]        oGreen,
    output logic [7:0]        oBlue,
    output logic [ADDR_W:0]   oFILL,
    output logic              oLOW_WATER,
    output logic              oUNDERFLOW
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0] LOW_WM_C = CNT_W'(LOW_WM);

    logic [23:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   count;
    logic [23:0]       pixel;
    logic              clearAll;
    logic              push;
    logic              pop;
    logic              emptyRead;

    // Reset and flush both discard any transfer in the same cycle.
    assign clearAll  = iRST || iFRAME_START;
    assign oWR_READY = (count < DEPTH_C);
    assign push      = iWR_VALID && oWR_READY && !clearAll;
    assign pop       = iREAD_Request && (count != '0) && !clearAll;
    assign emptyRead = iREAD_Request && (count == '0) && !clearAll;

    // Pixel storage; the write port has no reset, so it infers block RAM.
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wrPtr] <= iWR_DATA;
        end
    end

    // Synchronous read into the output register; it shows black unless a pop happens.
    always_ff @(posedge iCLK) begin
        if (pop) begin
            pixel <= mem[rdPtr];
        end else begin
            pixel <= '0;
        end
    end

    // Pointers and occupancy. The pointers wrap naturally at DEPTH = 2**ADDR_W.
    always_ff @(posedge iCLK) begin
        if (clearAll) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky underflow flag; only reset or flush clears it.
    always_ff @(posedge iCLK) begin
        if (clearAll) begin
            oUNDERFLOW <= 1'b0;
        end else if (emptyRead) begin
            oUNDERFLOW <= 1'b1;
        end
    end

    assign oRed       = pixel[23:16];
    assign oGreen     = pixel[15:8];
    assign oBlue      = pixel[7:0];
    assign oFILL      = count;
    assign oLOW_WATER = (count <= LOW_WM_C);

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Self-checking bench for vga_pixel_fifo: a queue-based reference model plus directed literal checks.
module tb_vga_pixel_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0;
    logic [23:0] wd = '0;
    logic        wv = 1'b0;
    logic        rq = 1'b0;
    logic        wrReady;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [9:0]  fill;
    logic        lowWater;
    logic        underflow;

    int nCheck = 0;
    int nPass  = 0;
    bit cmpEn  = 1'b0;

    // Reference model state.
    logic [23:0] mq[$];
    logic [23:0] mRgb = '0;
    logic        mUf = 1'b0;
    int          mSz;

    always #5 clk = ~clk;

    vga_pixel_fifo #(.ADDR_W(9), .DEPTH(512), .LOW_WM(128)) dut (
        .iCLK(clk),
        .iRST(rst),
        .iFRAME_START(fs),
        .iWR_DATA(wd),
        .iWR_VALID(wv),
        .oWR_READY(wrReady),
        .iREAD_Request(rq),
        .oRed(red),
        .oGreen(green),
        .oBlue(blue),
        .oFILL(fill),
        .oLOW_WATER(lowWater),
        .oUNDERFLOW(underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCheck++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO queue, updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        mSz = mq.size();
        if (rst || fs) begin
            mq.delete();
            mRgb = '0;
            mUf  = 1'b0;
        end else begin
            mRgb = '0;
            if (rq) begin
                if (mSz > 0) mRgb = mq.pop_front();
                else         mUf = 1'b1;
            end
            if (wv && mSz < 512) mq.push_back(wd);
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            check("m_fill", 32'(fill), 32'(mq.size()));
            check("m_ready", 32'(wrReady), 32'(mq.size() < 512));
            check("m_lowwater", 32'(lowWater), 32'(mq.size() <= 128));
            check("m_underflow", 32'(underflow), 32'(mUf));
            check("m_rgb", 32'({red, green, blue}), 32'(mRgb));
        end
    end

    task automatic cyc(input logic r, input logic f, input logic [23:0] d, input logic v, input logic q);
        rst = r; fs = f; wd = d; wv = v; rq = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then idle.
        cyc(1, 0, 24'h0, 0, 0);
        cyc(1, 0, 24'h0, 0, 0);
        cmpEn = 1'b1;
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_ready", 32'(wrReady), 32'd1);
        check("rst_lowwater", 32'(lowWater), 32'd1);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        cyc(0, 0, 24'h0, 0, 0);

        // Ordered fill and drain.
        cyc(0, 0, 24'h112233, 1, 0);
        cyc(0, 0, 24'h445566, 1, 0);
        cyc(0, 0, 24'h778899, 1, 0);
        check("ord_fill3", 32'(fill), 32'd3);
        cyc(0, 0, 24'h0, 0, 1);
        check("ord_r1", 32'(red), 32'h11);
        check("ord_g1", 32'(green), 32'h22);
        check("ord_b1", 32'(blue), 32'h33);
        cyc(0, 0, 24'h0, 0, 1);
        check("ord_rgb2", 32'({red, green, blue}), 32'h445566);
        cyc(0, 0, 24'h0, 0, 1);
        check("ord_rgb3", 32'({red, green, blue}), 32'h778899);
        check("ord_fill0", 32'(fill), 32'd0);
        cyc(0, 0, 24'h0, 0, 0);
        check("ord_blank", 32'({red, green, blue}), 32'd0);

        // Reset overrides a simultaneous push and pop.
        cyc(0, 0, 24'hA1A2A3, 1, 0);
        cyc(0, 0, 24'hB1B2B3, 1, 0);
        cyc(1, 0, 24'hC1C2C3, 1, 1);
        check("rstov_fill", 32'(fill), 32'd0);
        check("rstov_rgb", 32'({red, green, blue}), 32'd0);

        // Full.
        for (int i = 0; i < 512; i++) cyc(0, 0, 24'(32'h100000 + i), 1, 0);
        check("full_fill", 32'(fill), 32'd512);
        check("full_ready", 32'(wrReady), 32'd0);
        cyc(0, 0, 24'hABCDEF, 1, 0);
        check("full_reject", 32'(fill), 32'd512);
        cyc(0, 0, 24'h0, 0, 1);
        check("full_pop_fill", 32'(fill), 32'd511);
        check("full_pop_ready", 32'(wrReady), 32'd1);
        check("full_pop_rgb", 32'({red, green, blue}), 32'h100000);
        for (int i = 0; i < 382; i++) cyc(0, 0, 24'h0, 0, 1);
        check("lw_fill129", 32'(fill), 32'd129);
        check("lw_129", 32'(lowWater), 32'd0);
        cyc(0, 0, 24'h0, 0, 1);
        check("lw_fill128", 32'(fill), 32'd128);
        check("lw_128", 32'(lowWater), 32'd1);
        check("lw_rgb", 32'({red, green, blue}), 32'h100000 + 32'd383);
        cyc(0, 1, 24'h0, 0, 0);
        check("flush_fill", 32'(fill), 32'd0);

        // Underflow and simultaneous events.
        cyc(0, 0, 24'h0, 0, 1);
        check("uf_rgb", 32'({red, green, blue}), 32'd0);
        check("uf_flag", 32'(underflow), 32'd1);
        cyc(0, 1, 24'h0, 0, 0);
        check("uf_cleared", 32'(underflow), 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 24'(32'h200000 + i), 1, 0);
        cyc(0, 0, 24'h2000FF, 1, 1);
        check("pp5_fill", 32'(fill), 32'd5);
        check("pp5_rgb", 32'({red, green, blue}), 32'h200000);
        cyc(0, 1, 24'h0, 0, 0);
        cyc(0, 0, 24'h303030, 1, 1);
        check("pp0_fill", 32'(fill), 32'd1);
        check("pp0_uf", 32'(underflow), 32'd1);
        check("pp0_rgb", 32'({red, green, blue}), 32'd0);
        cyc(0, 0, 24'h0, 0, 1);
        check("pp0_stored", 32'({red, green, blue}), 32'h303030);
        cyc(0, 1, 24'h0, 0, 0);

        // Flush mid-stream.
        for (int i = 0; i < 300; i++) cyc(0, 0, 24'(32'h400000 + i), 1, 0);
        check("fl_fill300", 32'(fill), 32'd300);
        cyc(0, 0, 24'h0, 0, 0);
        cyc(0, 1, 24'h5A5A5A, 1, 1);
        check("fl_fill", 32'(fill), 32'd0);
        check("fl_uf", 32'(underflow), 32'd0);
        check("fl_rgb", 32'({red, green, blue}), 32'd0);
        cyc(0, 0, 24'h0, 0, 1);
        check("fl_discard_rgb", 32'({red, green, blue}), 32'd0);
        check("fl_discard_uf", 32'(underflow), 32'd1);
        cyc(0, 1, 24'h0, 0, 0);

        // Pointer wrap under streaming.
        for (int i = 0; i < 10; i++) cyc(0, 0, 24'(i), 1, 0);
        for (int j = 0; j < 1500; j++) begin
            cyc(0, 0, 24'(j + 10), 1, 1);
            check("wrap_rgb", 32'({red, green, blue}), 32'(j));
        end
        check("wrap_fill", 32'(fill), 32'd10);
        check("wrap_uf", 32'(underflow), 32'd0);
        cyc(0, 0, 24'h0, 0, 0);

        cmpEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nCheck);
        $finish;
    end

endmodule
